// File: rtl/fifo_flagged.sv
// Single-clock show-ahead FIFO with occupancy count, almost-full/almost-empty flags,
// flush and write-through at full. Define FIFO_FLAGGED_ERR_EN for sticky overflow/underflow outputs.
module fifo_flagged #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_FLAGGED_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] FULL_LVL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL =
    (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LVL =
    (ADDR_WIDTH+1)'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  hold;

  // flush or reset swallows any access presented in the same cycle
  assign hold   = reset | clr;
  assign wr_acc = wr & (~full | rd) & ~hold;
  assign rd_acc = rd & ~empty & ~hold;

  assign empty        = (count == '0);
  assign full         = (count == FULL_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign almost_full  = (count >= AF_LVL);

  assign r_data = mem[r_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[w_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      count <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_FLAGGED_ERR_EN
  always_ff @(posedge clk) begin
    if (hold) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full & ~rd) begin
        overflow <= 1'b1;
      end
      if (rd & empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed plus random bench for fifo_flagged (DEPTH=4) against a queue model.
// Error-flag checks compile in only when FIFO_FLAGGED_ERR_EN is defined.
module tb_fifo_flagged;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFM   = 1;
  localparam int AEM   = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   count;
`ifdef FIFO_FLAGGED_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  fifo_flagged #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count)
`ifdef FIFO_FLAGGED_ERR_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  n;
    bit  pop;
    bit  push;
    n = mq.size();
    if (reset || clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
      if (rd && n == 0) m_udf = 1'b1;
      pop  = rd && n > 0;
      push = wr && (n < DEPTH || rd);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(w_data);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == DEPTH));
    check("almost_empty", 32'(almost_empty), 32'(n <= AEM));
    check("almost_full", 32'(almost_full), 32'(n >= DEPTH - AFM));
    if (n > 0) check("r_data", 32'(r_data), 32'(mq[0]));
`ifdef FIFO_FLAGGED_ERR_EN
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
`endif
  endtask

  task automatic step(input logic i_wr, input logic [DW-1:0] i_d,
                      input logic i_rd, input logic i_clr,
                      input logic i_rst);
    wr     = i_wr;
    w_data = i_d;
    rd     = i_rd;
    clr    = i_clr;
    reset  = i_rst;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    // reset held two cycles with a write pending
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);

    // fill
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    check("fill3_af", 32'(almost_full), 32'd1);
    check("fill3_full", 32'(full), 32'd0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    check("fill4_full", 32'(full), 32'd1);
    check("fill4_head", 32'(r_data), 32'h11);

    // dropped write at full
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_head", 32'(r_data), 32'h11);

    // write-through at full
    step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    check("wt_count", 32'(count), 32'd4);
    check("wt_head", 32'(r_data), 32'h22);
    check("drain0", 32'(r_data), 32'h22);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drain1", 32'(r_data), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drain2", 32'(r_data), 32'h44);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drain3", 32'(r_data), 32'h66);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drained", 32'(empty), 32'd1);

    // wrap: pointers go round twice
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      check("wrap_data", 32'(r_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("wrap_cnt", 32'(count), 32'd0);
    end

    // flush mid-load then read on empty
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA4, 1'b0, 1'b1, 1'b0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("udf_count", 32'(count), 32'd0);

    // empty with simultaneous read and write
    step(1'b1, 8'hC7, 1'b1, 1'b0, 1'b0);
    check("er_w_count", 32'(count), 32'd1);
    check("er_w_head", 32'(r_data), 32'hC7);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
